fc1_weight_update_ctrl: RTL and testbench

- Read-modify-write engine for the FC1 weight BRAM during the SGD weight-update phase.
- Consumes a stream of gradient words, one word per BRAM address in ascending order.
- For each word: reads the current weight word on BRAM port A, applies w_new = sat(w - (g >>> LR_SHIFT)) per lane, and writes the result back on port B.
- Acts as the initiator that drives both ports of the FC1 weight BRAM controller. Throughput is one word per cycle.

---
 rtl/fc1_weight_update_ctrl.sv | 131 +++++++++++++
 tb/tb_fc1_weight_update_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc1_weight_update_ctrl.sv
// FC1 weight-update read-modify-write engine: w_new = sat(w - (g >>> LR_SHIFT)) per lane.
// Ports: clk, rst (async active-low); start/busy/done control; grad_valid/grad_ready/grad_data
// gradient stream; rd_addr/rd_en/rd_data BRAM port A; wr_addr/wr_data/wr_en/wr_we BRAM port B.
module fc1_weight_update_ctrl #(
    parameter int PORT_WIDTH = 8,
    parameter int PREC       = 16,
    parameter int ADDR_W     = 12,
    parameter int N_WORDS    = 1568,
    parameter int RD_LAT     = 2,
    parameter int LR_SHIFT   = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    input  logic                       grad_valid,
    output logic                       grad_ready,
    input  logic [PORT_WIDTH*PREC-1:0] grad_data,
    output logic [ADDR_W-1:0]          rd_addr,
    output logic                       rd_en,
    input  logic [PORT_WIDTH*PREC-1:0] rd_data,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [PORT_WIDTH*PREC-1:0] wr_data,
    output logic                       wr_en,
    output logic                       wr_we
);
    localparam int W  = PORT_WIDTH * PREC;
    localparam int CW = $clog2(N_WORDS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     issue_cnt;
    logic              hs;
    logic [RD_LAT-1:0] tag_vld;
    logic [ADDR_W-1:0] tag_addr [RD_LAT];
    logic [W-1:0]      tag_grad [RD_LAT];
    logic [W-1:0]      upd;

    assign grad_ready = (state == S_RUN) && (issue_cnt < CW'(N_WORDS));
    assign hs         = grad_valid & grad_ready;
    assign rd_en      = hs;
    assign rd_addr    = hs ? ADDR_W'(issue_cnt) : '0;
    assign busy       = (state == S_RUN) || (state == S_DRAIN);
    assign done       = (state == S_DONE);
    assign wr_we      = wr_en;

    // d is sign-extended to PREC+1 bits so the subtraction cannot wrap;
    // disagreeing top two bits of r mean the PREC-bit range was exceeded.
    function automatic logic [PREC-1:0] lane_upd(input logic [PREC-1:0] w,
                                                 input logic [PREC-1:0] g);
        logic [PREC:0] r;
        r = {w[PREC-1], w} - {{(LR_SHIFT+1){g[PREC-1]}}, g[PREC-1:LR_SHIFT]};
        if (r[PREC] != r[PREC-1])
            lane_upd = r[PREC] ? {1'b1, {(PREC-1){1'b0}}} : {1'b0, {(PREC-1){1'b1}}};
        else
            lane_upd = r[PREC-1:0];
    endfunction

    always_comb begin
        upd = '0;
        for (int i = 0; i < PORT_WIDTH; i++)
            upd[i*PREC +: PREC] = lane_upd(rd_data[i*PREC +: PREC],
                                           tag_grad[RD_LAT-1][i*PREC +: PREC]);
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (issue_cnt == CW'(N_WORDS)) state_nx = S_DRAIN;
            // Leave only once the last write has been on port B for its cycle.
            S_DRAIN: if (tag_vld == '0 && !wr_en) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            issue_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start)
                issue_cnt <= '0;
            else if (hs)
                issue_cnt <= issue_cnt + CW'(1);
        end
    end

    // Tag pipeline: entry RD_LAT-1 lines up with rd_data of the same read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                tag_addr[i] <= '0;
                tag_grad[i] <= '0;
            end
        end else begin
            tag_vld[0]  <= hs;
            tag_addr[0] <= ADDR_W'(issue_cnt);
            tag_grad[0] <= grad_data;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_addr[i] <= tag_addr[i-1];
                tag_grad[i] <= tag_grad[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= tag_vld[RD_LAT-1];
            if (tag_vld[RD_LAT-1]) begin
                wr_addr <= tag_addr[RD_LAT-1];
                wr_data <= upd;
            end
        end
    end
endmodule

// File: tb/tb_fc1_weight_update_ctrl.sv
// Testbench for fc1_weight_update_ctrl: three instances (N_WORDS 1568, 4, 1) with BRAM models,
// an event log per port and an arithmetic reference model of the SGD update.
module tb_fc1_weight_update_ctrl;
    localparam int W  = 128;
    localparam int NA = 1568;
    localparam int HB = 8000;

    typedef struct {
        int          k;
        int          a;
        logic [W-1:0] d;
        int          c;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         start_s [3];
    logic         gv_s    [3];
    logic [W-1:0] gd_s    [3];
    logic [W-1:0] rdd     [3];
    logic [W-1:0] p1      [3];
    logic         busy_a  [3];
    logic         done_a  [3];
    logic         gr_a    [3];
    logic [11:0]  rda_a   [3];
    logic         rden_a  [3];
    logic [11:0]  wra_a   [3];
    logic [W-1:0] wrd_a   [3];
    logic         wren_a  [3];
    logic         wrwe_a  [3];

    logic         ld_go = 1'b0;
    logic [W-1:0] wmem  [3][NA];
    logic [W-1:0] winit [3][NA];
    logic [W-1:0] gq    [3][NA];

    ev_t hs_q[$], rd_q[$], wr_q[$], dn_q[$], st_q[$];
    int  we_bad [3];
    bit  busy_h [3][HB];
    int  checks = 0;
    int  fails  = 0;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int NW = (k == 0) ? 1568 : (k == 1) ? 4 : 1;
        fc1_weight_update_ctrl #(.N_WORDS(NW)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start_s[k]),
            .busy       (busy_a[k]),
            .done       (done_a[k]),
            .grad_valid (gv_s[k]),
            .grad_ready (gr_a[k]),
            .grad_data  (gd_s[k]),
            .rd_addr    (rda_a[k]),
            .rd_en      (rden_a[k]),
            .rd_data    (rdd[k]),
            .wr_addr    (wra_a[k]),
            .wr_data    (wrd_a[k]),
            .wr_en      (wren_a[k]),
            .wr_we      (wrwe_a[k])
        );
    end

    // BRAM model: two-cycle read latency, write on port B, bulk load from winit.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rden_a[k]) p1[k] <= wmem[k][rda_a[k]];
            rdd[k] <= p1[k];
            if (wren_a[k]) wmem[k][wra_a[k]] <= wrd_a[k];
        end
        if (ld_go)
            for (int k = 0; k < 3; k++)
                for (int a = 0; a < NA; a++)
                    wmem[k][a] <= winit[k][a];
    end

    function automatic ev_t mk(input int k, input int a, input logic [W-1:0] d, input int c);
        ev_t e;
        e.k = k; e.a = a; e.d = d; e.c = c;
        return e;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (gv_s[k] && gr_a[k]) hs_q.push_back(mk(k, 0, gd_s[k], cyc));
            if (rden_a[k]) rd_q.push_back(mk(k, int'(rda_a[k]), '0, cyc));
            if (wren_a[k]) wr_q.push_back(mk(k, int'(wra_a[k]), wrd_a[k], cyc));
            if (done_a[k]) dn_q.push_back(mk(k, 0, '0, cyc));
            if (start_s[k]) st_q.push_back(mk(k, 0, '0, cyc));
            if (wrwe_a[k] !== wren_a[k]) we_bad[k]++;
            if (cyc < HB) busy_h[k][cyc] = busy_a[k];
        end
    end

    // Reference: floor division by 2^7, then clamp to the 16-bit signed range.
    function automatic logic [W-1:0] model(input logic [W-1:0] w, input logic [W-1:0] g);
        logic [W-1:0] r;
        int wi, gi, d, x;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            wi = int'($signed(w[i*16 +: 16]));
            gi = int'($signed(g[i*16 +: 16]));
            d  = (gi >= 0) ? gi / 128 : -((-gi + 127) / 128);
            x  = wi - d;
            if (x > 32767) x = 32767;
            if (x < -32768) x = -32768;
            r[i*16 +: 16] = x[15:0];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        hs_q.delete(); rd_q.delete(); wr_q.delete(); dn_q.delete(); st_q.delete();
    endtask

    task automatic load_bram();
        ld_go = 1'b1;
        @(posedge clk); #1;
        ld_go = 1'b0;
    endtask

    task automatic run_pass(input int k, input int n, input bit hold, input bit bub,
                            input bit st_run);
        int idx = 0;
        int step = 0;
        int g = 0;
        bit hs;
        logic [4:0] pat = 5'b01101;
        start_s[k] = 1'b1;
        @(posedge clk); #1;
        start_s[k] = 1'b0;
        while (idx < n && g < 4 * n + 50) begin
            gv_s[k]    = bub ? pat[step % 5] : 1'b1;
            gd_s[k]    = gq[k][idx];
            start_s[k] = st_run && (step == 5);
            hs = gv_s[k] && gr_a[k];
            @(posedge clk); #1;
            if (hs) idx++;
            step++;
            g++;
        end
        start_s[k] = 1'b0;
        chk($sformatf("k%0d:handshakes", k), idx, n);
        gv_s[k] = hold;
        g = 0;
        while (!done_a[k] && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        chk($sformatf("k%0d:done_seen", k), done_a[k], 1'b1);
        gv_s[k] = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic check_pass(input int k, input int n, input string nm, output int dc,
                              output int sc, output logic [W-1:0] wd0);
        ev_t h[$], r[$], w[$], d[$], s[$];
        int lim, lo;
        foreach (hs_q[i]) if (hs_q[i].k == k) h.push_back(hs_q[i]);
        foreach (rd_q[i]) if (rd_q[i].k == k) r.push_back(rd_q[i]);
        foreach (wr_q[i]) if (wr_q[i].k == k) w.push_back(wr_q[i]);
        foreach (dn_q[i]) if (dn_q[i].k == k) d.push_back(dn_q[i]);
        foreach (st_q[i]) if (st_q[i].k == k) s.push_back(st_q[i]);
        chk({nm, ":n_hs"}, h.size(), n);
        chk({nm, ":n_rd"}, r.size(), n);
        chk({nm, ":n_wr"}, w.size(), n);
        chk({nm, ":n_done"}, d.size(), 1);
        lim = n;
        if (h.size() < lim) lim = h.size();
        if (r.size() < lim) lim = r.size();
        if (w.size() < lim) lim = w.size();
        for (int i = 0; i < lim; i++) begin
            chk($sformatf("%s:rd_addr[%0d]", nm, i), r[i].a, i);
            chk($sformatf("%s:rd_cyc[%0d]", nm, i), r[i].c, h[i].c);
            chk($sformatf("%s:wr_addr[%0d]", nm, i), w[i].a, i);
            chk($sformatf("%s:wr_data[%0d]", nm, i), w[i].d, model(winit[k][i], gq[k][i]));
            chk($sformatf("%s:wr_cyc[%0d]", nm, i), w[i].c, h[i].c + 3);
        end
        dc  = (d.size() > 0) ? d[0].c : -1;
        sc  = (s.size() > 0) ? s[0].c : -1;
        wd0 = (w.size() > 0) ? w[0].d : 'x;
        if (w.size() > 0) chk({nm, ":done_gap"}, dc - w[w.size()-1].c, 2);
        if (sc >= 0 && dc > sc && dc < HB) begin
            lo = 0;
            for (int c = sc + 1; c < dc; c++) if (!busy_h[k][c]) lo++;
            chk({nm, ":busy_low_cycles"}, lo, 0);
            chk({nm, ":busy_at_start"}, busy_h[k][sc], 1'b0);
            chk({nm, ":busy_at_done"}, busy_h[k][dc], 1'b0);
        end
        chk({nm, ":wr_we"}, we_bad[k], 0);
        for (int a = 0; a < n; a++) winit[k][a] = model(winit[k][a], gq[k][a]);
        clear_logs();
    endtask

    task automatic chk_zero(input int k, input string nm);
        chk({nm, ":busy"}, busy_a[k], 1'b0);
        chk({nm, ":done"}, done_a[k], 1'b0);
        chk({nm, ":grad_ready"}, gr_a[k], 1'b0);
        chk({nm, ":rd_en"}, rden_a[k], 1'b0);
        chk({nm, ":rd_addr"}, rda_a[k], 12'd0);
        chk({nm, ":wr_en"}, wren_a[k], 1'b0);
        chk({nm, ":wr_we"}, wrwe_a[k], 1'b0);
        chk({nm, ":wr_addr"}, wra_a[k], 12'd0);
        chk({nm, ":wr_data"}, wrd_a[k], '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, sc, dc1, idx, g, nw, nr;
        bit hs;
        logic [W-1:0] wd, wv, gv;

        for (int k = 0; k < 3; k++) begin
            start_s[k] = 1'b0;
            gv_s[k]    = 1'b0;
            gd_s[k]    = '0;
            we_bad[k]  = 0;
            for (int a = 0; a < NA; a++) begin
                winit[k][a] = rnd();
                gq[k][a]    = rnd();
            end
        end
        load_bram();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk_zero(k, $sformatf("reset_k%0d", k));
        rst = 1'b1;
        @(posedge clk); #1;
        clear_logs();

        // N_WORDS=1: directed lanes covering rounding and both saturation rails.
        wv = '0; gv = '0;
        wv[15:0]    = 16'd1000;  gv[15:0]    = 16'd1280;
        wv[31:16]   = 16'd5;     gv[31:16]   = 16'hffff;
        wv[47:32]   = 16'd77;    gv[47:32]   = 16'd127;
        wv[63:48]   = 16'd32760; gv[63:48]   = 16'hf600;
        wv[79:64]   = 16'h8008;  gv[79:64]   = 16'h0a00;
        wv[95:80]   = 16'hffff;  gv[95:80]   = 16'h8000;
        wv[111:96]  = 16'h1234;  gv[111:96]  = 16'h0000;
        wv[127:112] = 16'h0000;  gv[127:112] = 16'h0080;
        winit[2][0] = wv;
        gq[2][0]    = gv;
        load_bram();
        clear_logs();
        run_pass(2, 1, 1'b0, 1'b0, 1'b0);
        check_pass(2, 1, "n1", dc, sc, wd);
        chk("n1:lane0_basic", wd[15:0], 16'd990);
        chk("n1:lane1_floor_neg", wd[31:16], 16'd6);
        chk("n1:lane2_floor_zero", wd[47:32], 16'd77);
        chk("n1:lane3_sat_max", wd[63:48], 16'h7fff);
        chk("n1:lane4_sat_min", wd[79:64], 16'h8000);
        chk("n1:lane5_big_neg_g", wd[95:80], 16'd255);
        chk("n1:lane6_zero_g", wd[111:96], 16'h1234);
        chk("n1:lane7_minus_one", wd[127:112], 16'hffff);

        // N_WORDS=4 with bubbles, then an immediate back-to-back pass.
        for (int a = 0; a < 4; a++) gq[1][a] = rnd();
        clear_logs();
        run_pass(1, 4, 1'b0, 1'b1, 1'b0);
        check_pass(1, 4, "bub", dc1, sc, wd);
        for (int a = 0; a < 4; a++) gq[1][a] = rnd();
        @(posedge clk); #1;
        run_pass(1, 4, 1'b0, 1'b0, 1'b0);
        check_pass(1, 4, "b2b", dc, sc, wd);
        chk("b2b:start_cycle", sc, dc1 + 1);

        // Reset in the middle of a full-rate pass.
        for (int a = 0; a < NA; a++) gq[0][a] = rnd();
        clear_logs();
        start_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        idx = 0;
        g = 0;
        while (idx < 10 && g < 100) begin
            gv_s[0] = 1'b1;
            gd_s[0] = gq[0][idx];
            hs = gr_a[0];
            @(posedge clk); #1;
            if (hs) idx++;
            g++;
        end
        chk("rst:pre_wr_en", wren_a[0], 1'b1);
        chk("rst:pre_busy", busy_a[0], 1'b1);
        rst = 1'b0;
        #1;
        chk_zero(0, "rst_async");
        gv_s[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clear_logs();
        rst = 1'b1;
        gv_s[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        gv_s[0] = 1'b0;
        nw = 0;
        nr = 0;
        foreach (wr_q[i]) if (wr_q[i].k == 0) nw++;
        foreach (rd_q[i]) if (rd_q[i].k == 0) nr++;
        chk("rst:writes_after_release", nw, 0);
        chk("rst:reads_after_release", nr, 0);
        chk("rst:busy_after_release", busy_a[0], 1'b0);

        // Fresh full-rate pass from address 0, with a stray start while running.
        for (int a = 0; a < NA; a++) begin
            winit[0][a] = rnd();
            gq[0][a]    = rnd();
        end
        load_bram();
        clear_logs();
        run_pass(0, NA, 1'b1, 1'b0, 1'b1);
        check_pass(0, NA, "full", dc, sc, wd);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
